// File: rtl/bullcow_pkg.sv
// Shared Bulls&Cows types: game state encoding, display glyphs and the frame snapshot.
package bullcow_pkg;

   typedef enum logic [2:0] {
      J1_SETUP = 3'b000,
      J2_SETUP = 3'b001,
      J1_GUESS = 3'b010,
      J2_GUESS = 3'b011,
      END_GAME = 3'b111
   } state_t;

   typedef enum logic [4:0] {
      HEX0 = 5'd0,  HEX1 = 5'd1,  HEX2 = 5'd2,  HEX3 = 5'd3,
      HEX4 = 5'd4,  HEX5 = 5'd5,  HEX6 = 5'd6,  HEX7 = 5'd7,
      HEX8 = 5'd8,  HEX9 = 5'd9,  HEXA = 5'd10, HEXB = 5'd11,
      HEXC = 5'd12, HEXD = 5'd13, HEXE = 5'd14, HEXF = 5'd15,
      G_J = 5'd16, G_P = 5'd17, G_S = 5'd18, G_T = 5'd19,
      G_C_LO = 5'd20, G_DASH = 5'd21, G_BLANK = 5'd22
   } glyph_t;

   // state is kept as raw bits so the unused codes 100/101/110 survive the snapshot
   typedef struct packed {
      logic [2:0] state;
      logic [2:0] bull;
      logic [2:0] cow;
      logic [7:0] p1;
      logic [7:0] p2;
   } frame_t;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   function automatic glyph_t nib_glyph(input logic [3:0] nib);
      return glyph_t'({1'b0, nib});
   endfunction

endpackage

// File: rtl/bullcow_display_if.sv
// Game-core to display bundle: game status inputs plus the multiplexed digit/segment drive.
interface bullcow_display_if;
   logic [2:0] game_state;
   logic [2:0] bull_count;
   logic [2:0] cow_count;
   logic [7:0] J1_points;
   logic [7:0] J2_points;
   logic [7:0] an;
   logic [7:0] seg;

   modport master (
      output game_state, bull_count, cow_count, J1_points, J2_points,
      input  an, seg
   );

   modport slave (
      input  game_state, bull_count, cow_count, J1_points, J2_points,
      output an, seg
   );
endinterface

// File: rtl/bullcow_display_seg7_glyph.sv
// Glyph to active-low {dp,g,f,e,d,c,b,a} segment pattern; the one and only code table.
module seg7_glyph
   import bullcow_pkg::*;
(
   input  glyph_t     glyph_i,
   output logic [7:0] seg_o
);

   // Segment lookup
   always_comb begin
      seg_o = SEG_OFF;
      case (glyph_i)
         HEX0:    seg_o = 8'hC0;
         HEX1:    seg_o = 8'hF9;
         HEX2:    seg_o = 8'hA4;
         HEX3:    seg_o = 8'hB0;
         HEX4:    seg_o = 8'h99;
         HEX5:    seg_o = 8'h92;
         HEX6:    seg_o = 8'h82;
         HEX7:    seg_o = 8'hF8;
         HEX8:    seg_o = 8'h80;
         HEX9:    seg_o = 8'h90;
         HEXA:    seg_o = 8'h88;
         HEXB:    seg_o = 8'h83;
         HEXC:    seg_o = 8'hC6;
         HEXD:    seg_o = 8'hA1;
         HEXE:    seg_o = 8'h86;
         HEXF:    seg_o = 8'h8E;
         G_J:     seg_o = 8'hE1;
         G_P:     seg_o = 8'h8C;
         G_S:     seg_o = 8'h92;
         G_T:     seg_o = 8'h87;
         G_C_LO:  seg_o = 8'hA7;
         G_DASH:  seg_o = 8'hBF;
         G_BLANK: seg_o = SEG_OFF;
         default: seg_o = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/bullcow_display.sv
// 8-digit multiplexed 7-segment driver for the Bulls&Cows core: per-state messages,
// frame-atomic input snapshot and a blinking score screen at game end.
module bullcow_display
   import bullcow_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 100_000,
   parameter int unsigned BLINK_DIV = 25_000_000
) (
   input logic             clock,
   input logic             reset,
   bullcow_display_if.slave bus
);

   localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
   localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [SCAN_W-1:0]  prescaler_q, prescaler_d;
   logic [2:0]         idx_q, idx_d;
   frame_t             frame_q, frame_d;
   logic               frame_vld_q, frame_vld_d;
   logic               lit_q, lit_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_on_q, blink_on_d;
   logic [7:0]         an_q, an_d;
   logic [7:0]         seg_q, seg_d;

   logic   tick_s, snap_s, end_s, dark_s;
   glyph_t glyph_s, player_s;
   logic [7:0] glyph_seg_s;

   // Scan timing, frame snapshot, blink control and output next-state
   always_comb begin
      tick_s      = (prescaler_q == SCAN_LAST);
      snap_s      = tick_s && (idx_q == 3'd7);
      prescaler_d = tick_s ? '0 : prescaler_q + 1'b1;
      idx_d       = tick_s ? idx_q + 3'd1 : idx_q;
      lit_d       = tick_s ? 1'b1 : lit_q;
      frame_d     = frame_q;
      frame_vld_d = frame_vld_q;
      if (snap_s) begin
         frame_d     = {bus.game_state, bus.bull_count, bus.cow_count,
                        bus.J1_points, bus.J2_points};
         frame_vld_d = 1'b1;
      end else begin
         frame_d     = frame_q;
         frame_vld_d = frame_vld_q;
      end

      end_s       = frame_vld_q && (frame_q.state == END_GAME);
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      if (!end_s) begin
         blink_cnt_d = '0;
         blink_on_d  = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         blink_on_d  = ~blink_on_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end

      // the blink phase only matters while the shown frame is the score screen
      dark_s = !lit_q || (end_s && !blink_on_q);
      an_d   = dark_s ? AN_OFF  : ~(8'b0000_0001 << idx_q);
      seg_d  = dark_s ? SEG_OFF : glyph_seg_s;
   end

   // Glyph selection for the digit currently scanned
   always_comb begin
      glyph_s  = G_BLANK;
      player_s = frame_q.state[0] ? HEX2 : HEX1;
      if (!frame_vld_q) begin
         glyph_s = G_BLANK;
      end else begin
         case (frame_q.state)
            J1_SETUP, J2_SETUP: begin
               case (idx_q)
                  3'd7:    glyph_s = G_J;
                  3'd6:    glyph_s = player_s;
                  3'd3:    glyph_s = G_S;
                  3'd2:    glyph_s = HEXE;
                  3'd1:    glyph_s = G_T;
                  default: glyph_s = G_BLANK;
               endcase
            end
            J1_GUESS, J2_GUESS: begin
               case (idx_q)
                  3'd7:    glyph_s = G_J;
                  3'd6:    glyph_s = player_s;
                  3'd4:    glyph_s = HEXB;
                  3'd3:    glyph_s = nib_glyph({1'b0, frame_q.bull});
                  3'd1:    glyph_s = G_C_LO;
                  3'd0:    glyph_s = nib_glyph({1'b0, frame_q.cow});
                  default: glyph_s = G_BLANK;
               endcase
            end
            END_GAME: begin
               case (idx_q)
                  3'd7:    glyph_s = G_P;
                  3'd6:    glyph_s = HEX1;
                  3'd5:    glyph_s = nib_glyph(frame_q.p1[7:4]);
                  3'd4:    glyph_s = nib_glyph(frame_q.p1[3:0]);
                  3'd3:    glyph_s = G_P;
                  3'd2:    glyph_s = HEX2;
                  3'd1:    glyph_s = nib_glyph(frame_q.p2[7:4]);
                  3'd0:    glyph_s = nib_glyph(frame_q.p2[3:0]);
                  default: glyph_s = G_BLANK;
               endcase
            end
            default: glyph_s = G_DASH;
         endcase
      end
   end

   seg7_glyph u_glyph (
      .glyph_i (glyph_s),
      .seg_o   (glyph_seg_s)
   );

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prescaler_q <= '0;
         idx_q       <= 3'd0;
         frame_q     <= '0;
         frame_vld_q <= 1'b0;
         lit_q       <= 1'b0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         an_q        <= AN_OFF;
         seg_q       <= SEG_OFF;
      end else begin
         prescaler_q <= prescaler_d;
         idx_q       <= idx_d;
         frame_q     <= frame_d;
         frame_vld_q <= frame_vld_d;
         lit_q       <= lit_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;

endmodule

// File: tb/tb_bullcow_display.sv
// Self-checking bench for bullcow_display: fixed vector table, multi-cycle corner
// sequences and randomized frames checked against a character-level display model.
module tb_bullcow_display;
   import bullcow_pkg::*;

   localparam int SD = 4;
   localparam int BD = 16;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   bullcow_display_if bus ();

   bullcow_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_pass = 0;
   int n_chk  = 0;

   typedef struct {
      logic [2:0]  st;
      logic [2:0]  b;
      logic [2:0]  c;
      logic [7:0]  p1;
      logic [7:0]  p2;
      logic [63:0] exp;
      string       name;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [7:0] code_of(input byte ch);
      case (ch)
         "0": return 8'hC0;  "1": return 8'hF9;  "2": return 8'hA4;  "3": return 8'hB0;
         "4": return 8'h99;  "5": return 8'h92;  "6": return 8'h82;  "7": return 8'hF8;
         "8": return 8'h80;  "9": return 8'h90;  "A": return 8'h88;  "b": return 8'h83;
         "C": return 8'hC6;  "d": return 8'hA1;  "E": return 8'h86;  "F": return 8'h8E;
         "J": return 8'hE1;  "P": return 8'h8C;  "S": return 8'h92;  "t": return 8'h87;
         "c": return 8'hA7;  "-": return 8'hBF;
         default: return 8'hFF;
      endcase
   endfunction

   // The display text as a string, leftmost character = d7
   function automatic logic [63:0] model(input logic [2:0] st, input logic [2:0] b,
                                         input logic [2:0] c, input logic [7:0] p1,
                                         input logic [7:0] p2);
      string hx = "0123456789AbCdEF";
      string s;
      logic [63:0] r;
      case (st)
         3'd0, 3'd1: s = $sformatf("J%0d  SEt ", int'(st) + 1);
         3'd2, 3'd3: s = $sformatf("J%0d b%c c%c", int'(st) - 1, hx[int'(b)], hx[int'(c)]);
         3'd7: s = $sformatf("P1%c%cP2%c%c", hx[int'(p1[7:4])], hx[int'(p1[3:0])],
                             hx[int'(p2[7:4])], hx[int'(p2[3:0])]);
         default: s = "--------";
      endcase
      for (int i = 0; i < 8; i++) r[8*(7-i) +: 8] = code_of(s[i]);
      return r;
   endfunction

   task automatic set_in(input logic [2:0] st, input logic [2:0] b, input logic [2:0] c,
                         input logic [7:0] p1, input logic [7:0] p2);
      bus.game_state = st;
      bus.bull_count = b;
      bus.cow_count  = c;
      bus.J1_points  = p1;
      bus.J2_points  = p2;
   endtask

   // Waits for the negedge where d0 newly lights (start of a displayed frame)
   task automatic wait_onset(output bit ok);
      logic [7:0] prev;
      prev = bus.an;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clock);
         if (bus.an == 8'hFE && prev != 8'hFE) ok = 1'b1;
         prev = bus.an;
      end
   endtask

   task automatic check_frame(input string name, input logic [63:0] exp, input bit is_end);
      bit ok, ok2;
      logic [7:0] seen;
      logic [7:0] an;
      int bad, zeros, j;
      seen = 8'h00;
      bad = 0;
      wait_onset(ok);
      wait_onset(ok2);
      if (!(ok && ok2)) begin
         n_chk++;
         $display("FAIL %s: no frame start within cycle budget", name);
         return;
      end
      for (int k = 0; k < 8 * SD; k++) begin
         if (k > 0) @(negedge clock);
         an = bus.an;
         if (an == 8'hFF) begin
            if (!is_end || bus.seg != 8'hFF) bad++;
         end else begin
            zeros = 0;
            j = 0;
            for (int d = 0; d < 8; d++) if (!an[d]) begin zeros++; j = d; end
            if (zeros != 1) bad++;
            else if (!seen[j]) begin
               seen[j] = 1'b1;
               chk($sformatf("%s d%0d", name, j), 64'(bus.seg), 64'(exp[8*j +: 8]));
            end
         end
      end
      chk($sformatf("%s bad samples", name), 64'(bad), 64'd0);
      chk($sformatf("%s digits seen", name), 64'(seen), is_end ? 64'h0F : 64'hFF);
   endtask

   task automatic check_release(input string name);
      int cyc;
      cyc = 0;
      reset = 1'b0;
      while (bus.an == 8'hFF && cyc < 50) begin
         @(negedge clock);
         cyc++;
      end
      chk({name, " first lit cycle"}, 64'(cyc), 64'(SD + 1));
      chk({name, " first an"}, 64'(bus.an), 64'hFD);
      chk({name, " first seg blank"}, 64'(bus.seg), 64'hFF);
   endtask

   task automatic bull_change_seq();
      bit ok;
      int k;
      k = 0;
      while (bus.an != 8'hF7 && k < 100) begin @(negedge clock); k++; end
      chk("seq3 reach d3", 64'(bus.an), 64'hF7);
      bus.bull_count = 3'd3;
      k = 0;
      while (bus.an == 8'hF7 && k < 10) begin
         chk("seq3 d3 held", 64'(bus.seg), 64'hA4);
         @(negedge clock);
         k++;
      end
      wait_onset(ok);
      chk("seq3 onset", 64'(ok), 64'd1);
      k = 0;
      while (bus.an != 8'hF7 && k < 100) begin @(negedge clock); k++; end
      chk("seq3 d3 updated", 64'(bus.seg), 64'hB0);
   endtask

   task automatic blink_seq();
      bit cur, prev, started;
      int run, nruns;
      started = 1'b0;
      nruns = 0;
      run = 1;
      @(negedge clock);
      prev = (bus.an != 8'hFF);
      for (int k = 1; k < 128; k++) begin
         @(negedge clock);
         cur = (bus.an != 8'hFF);
         if (cur == prev) run++;
         else begin
            if (started) begin
               chk($sformatf("blink window %0d", nruns), 64'(run), 64'(BD));
               nruns++;
            end
            started = 1'b1;
            run = 1;
            prev = cur;
         end
      end
      chk("blink window count", 64'(nruns >= 6), 64'd1);
   endtask

   initial begin
      tbl[0] = '{3'b010, 3'd2, 3'd1, 8'h00, 8'h00, 64'hE1F9FF83A4FFA7F9, "j1guess"};
      tbl[1] = '{3'b001, 3'd0, 3'd0, 8'h00, 8'h00, 64'hE1A4FFFF928687FF, "j2setup"};
      tbl[2] = '{3'b011, 3'd7, 3'd5, 8'h11, 8'h22, 64'hE1A4FF83F8FFA792, "j2guess"};
      tbl[3] = '{3'b101, 3'd4, 3'd4, 8'h00, 8'h00, 64'hBFBFBFBFBFBFBFBF, "code101"};
      tbl[4] = '{3'b100, 3'd1, 3'd6, 8'h00, 8'h00, 64'hBFBFBFBFBFBFBFBF, "code100"};
      tbl[5] = '{3'b111, 3'd0, 3'd0, 8'h0A, 8'h03, 64'h8CF9C0888CA4C0B0, "endgame"};
      tbl[6] = '{3'b000, 3'd0, 3'd0, 8'h0A, 8'h03, 64'hE1F9FFFF928687FF, "j1setup"};
      tbl[7] = '{3'b110, 3'd0, 3'd0, 8'h00, 8'h00, 64'hBFBFBFBFBFBFBFBF, "code110"};

      reset = 1'b1;
      set_in(3'b010, 3'd2, 3'd1, 8'h00, 8'h00);
      repeat (3) @(negedge clock);
      chk("reset an", 64'(bus.an), 64'hFF);
      chk("reset seg", 64'(bus.seg), 64'hFF);
      check_release("por");

      for (int i = 0; i < 8; i++) begin
         set_in(tbl[i].st, tbl[i].b, tbl[i].c, tbl[i].p1, tbl[i].p2);
         check_frame(tbl[i].name, tbl[i].exp, tbl[i].st == 3'b111);
         if (i == 0) bull_change_seq();
         if (i == 5) blink_seq();
      end

      for (int r = 0; r < 12; r++) begin
         logic [2:0] st, b, c;
         logic [7:0] p1, p2;
         st = 3'($urandom_range(0, 7));
         b  = 3'($urandom_range(0, 7));
         c  = 3'($urandom_range(0, 7));
         p1 = 8'($urandom_range(0, 255));
         p2 = 8'($urandom_range(0, 255));
         set_in(st, b, c, p1, p2);
         check_frame($sformatf("rand%0d st%0d", r, st), model(st, b, c, p1, p2), st == 3'b111);
      end

      set_in(3'b011, 3'd4, 3'd2, 8'h00, 8'h00);
      repeat (45) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("midreset an", 64'(bus.an), 64'hFF);
      chk("midreset seg", 64'(bus.seg), 64'hFF);
      repeat (2) @(negedge clock);
      check_release("midreset");
      check_frame("after reset", model(3'b011, 3'd4, 3'd2, 8'h00, 8'h00), 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
